// File: rtl/nibble_serial_alu.sv
// nibble_serial_alu: 16-bit ALU that processes one 4-bit nibble per cycle.
// Operations: AND, OR, ADD, SUB, SLT (signed less-than); other op codes
// complete with a zero result.
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   in_valid/in_ready       operand bundle handshake (a, b, op)
//   a, b [15:0], op [2:0]   operands and operation code
//   out_valid/out_ready     result handshake
//   result [15:0]           final result, held stable while out_valid
//   cout, overflow, zero    carry out of bit 15, signed overflow, result==0
module nibble_serial_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        cout,
  output logic        overflow,
  output logic        zero
);

  localparam int unsigned DataW = 16;
  localparam int unsigned NibW  = 4;
  localparam int unsigned IdxW  = 2;
  localparam int unsigned OpW   = 3;

  localparam logic [OpW-1:0] OpAnd = 3'b000;
  localparam logic [OpW-1:0] OpOr  = 3'b001;
  localparam logic [OpW-1:0] OpAdd = 3'b010;
  localparam logic [OpW-1:0] OpSub = 3'b110;
  localparam logic [OpW-1:0] OpSlt = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [DataW-1:0] a_q, a_d;
  logic [DataW-1:0] b_q, b_d;
  logic [OpW-1:0]   op_q, op_d;
  logic [DataW-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [DataW-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             accept_c;
  logic             last_c;
  logic             is_sub_c;
  logic             is_arith_c;
  logic [NibW-1:0]  a_nib_c;
  logic [NibW-1:0]  b_nib_c;
  logic [NibW-1:0]  b_eff_c;
  logic             cin_c;
  logic [NibW:0]    sum_c;
  logic [NibW-1:0]  nib_res_c;
  logic             ovf_c;
  logic [DataW-1:0] final_c;

  assign accept_c   = in_valid && in_ready_q;
  assign last_c     = (idx_q == IdxW'(3));
  assign is_sub_c   = (op_q == OpSub) || (op_q == OpSlt);
  assign is_arith_c = is_sub_c || (op_q == OpAdd);

  // Nibble slice of the latched operands selected by the nibble index.
  assign a_nib_c = a_q[{idx_q, 2'b00} +: NibW];
  assign b_nib_c = b_q[{idx_q, 2'b00} +: NibW];

  // Subtraction is A + ~B + 1: invert B and seed carry-in of nibble 0.
  assign b_eff_c = is_sub_c ? ~b_nib_c : b_nib_c;
  assign cin_c   = (idx_q == IdxW'(0)) ? is_sub_c : carry_q;
  assign sum_c   = {1'b0, a_nib_c} + {1'b0, b_eff_c} + (NibW+1)'(cin_c);

  // Per-nibble result; undefined op codes yield zero.
  always_comb begin
    nib_res_c = '0;
    case (op_q)
      OpAnd:               nib_res_c = a_nib_c & b_nib_c;
      OpOr:                nib_res_c = a_nib_c | b_nib_c;
      OpAdd, OpSub, OpSlt: nib_res_c = sum_c[NibW-1:0];
      default:             nib_res_c = '0;
    endcase
  end

  // Signed overflow, meaningful only while the top nibble is processed.
  assign ovf_c = is_arith_c && (a_q[DataW-1] == b_eff_c[NibW-1]) &&
                 (sum_c[NibW-1] != a_q[DataW-1]);

  // Final 16-bit word; SLT corrects the sign bit with overflow.
  always_comb begin
    final_c = {nib_res_c, acc_q[DataW-NibW-1:0]};
    if (op_q == OpSlt) begin
      final_c = {15'b0, sum_c[NibW-1] ^ ovf_c};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and registered handshake outputs.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: if (accept_c) state_d = S_RUN;
      S_RUN:  if (last_c) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // Datapath next-state: latch on accept, one nibble per RUN cycle.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    if (state_q == S_IDLE) begin
      if (accept_c) begin
        a_d     = a;
        b_d     = b;
        op_d    = op;
        acc_d   = '0;
        carry_d = 1'b0;
        idx_d   = '0;
      end
    end else if (state_q == S_RUN) begin
      acc_d[{idx_q, 2'b00} +: NibW] = nib_res_c;
      carry_d = is_arith_c ? sum_c[NibW] : 1'b0;
      idx_d   = idx_q + IdxW'(1);
      if (last_c) begin
        result_d = final_c;
        cout_d   = is_arith_c ? sum_c[NibW] : 1'b0;
        ovf_d    = ovf_c;
        zero_d   = (final_c == '0);
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_alu.sv
// tb_nibble_serial_alu: directed bench for nibble_serial_alu.
module tb_nibble_serial_alu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        overflow;
  logic        zero;

  int vectors;
  int errors;

  nibble_serial_alu dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a bundle at a negedge; accepted on the following posedge.
  // Inputs are scrambled right after the accept edge.
  task automatic accept(input logic [2:0] o, input logic [15:0] aa, input logic [15:0] bb);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    op = o; a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a  = 16'($urandom);
    b  = 16'($urandom);
    op = 3'($urandom);
    chk("in_ready_run", 32'(in_ready), 32'd0);
  endtask

  // out_valid must be low after edge T+3 and high after edge T+4.
  task automatic wait_done();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("out_valid_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("out_valid_t4", 32'(out_valid), 32'd1);
  endtask

  task automatic chk_out(input string tag, input logic [15:0] r, input logic c,
                         input logic v, input logic z);
    chk({tag, "_result"}, 32'(result), 32'(r));
    chk({tag, "_cout"}, 32'(cout), 32'(c));
    chk({tag, "_ovf"}, 32'(overflow), 32'(v));
    chk({tag, "_zero"}, 32'(zero), 32'(z));
  endtask

  // Handshake the result while offering a bundle; it must not be taken.
  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op = 3'b010; a = 16'h1111; b = 16'h2222;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("out_valid_fall", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    vectors   = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk_out("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    #20;
    reset = 1'b0;

    // ADD with signed overflow
    accept(3'b010, 16'h7FFF, 16'h0001);
    wait_done();
    chk_out("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0);
    release_out();

    // SUB equal operands
    accept(3'b110, 16'h1234, 16'h1234);
    wait_done();
    chk_out("sub_eq", 16'h0000, 1'b1, 1'b0, 1'b1);
    release_out();

    // SLT with overflowing subtraction
    accept(3'b111, 16'h8000, 16'h0001);
    wait_done();
    chk_out("slt_ovf", 16'h0001, 1'b1, 1'b1, 1'b0);
    release_out();

    // SLT 5 < -1 is false
    accept(3'b111, 16'h0005, 16'hFFFF);
    wait_done();
    chk_out("slt_pos", 16'h0000, 1'b0, 1'b0, 1'b1);
    release_out();

    // ADD wrapping to zero with carry out
    accept(3'b010, 16'hFFFF, 16'h0001);
    wait_done();
    chk_out("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
    release_out();

    // OR
    accept(3'b001, 16'hA050, 16'h0C03);
    wait_done();
    chk_out("or", 16'hAC53, 1'b0, 1'b0, 1'b0);
    release_out();

    // AND with 10 cycles of back-pressure
    accept(3'b000, 16'hF0F0, 16'hFF00);
    wait_done();
    chk_out("and", 16'hF000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", 32'(result), 32'h0000F000);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    release_out();

    // Reset during the 2nd RUN cycle discards the operation
    accept(3'b010, 16'h0100, 16'h0200);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rstrun_in_ready", 32'(in_ready), 32'd1);
    chk("rstrun_out_valid", 32'(out_valid), 32'd0);
    chk("rstrun_result", 32'(result), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("rstrun_no_valid", 32'(out_valid), 32'd0);
    chk("rstrun_idle", 32'(in_ready), 32'd1);

    // ADD after reset
    accept(3'b010, 16'h0001, 16'h0001);
    wait_done();
    chk_out("add_small", 16'h0002, 1'b0, 1'b0, 1'b0);
    release_out();

    // Undefined op code
    accept(3'b100, 16'hBEEF, 16'h1234);
    wait_done();
    chk_out("undef", 16'h0000, 1'b0, 1'b0, 1'b1);
    release_out();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_alu.md
NIBBLE_SERIAL_ALU -- requirements
Module: nibble_serial_alu

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port: in_valid  input  1  operand/op bundle offered.
REQ-004 SHALL have port: in_ready  output  1  block can accept a bundle.
REQ-005 SHALL have port: a  input  16  operand A, two's complement.
REQ-006 SHALL have port: b  input  16  operand B, two's complement.
REQ-007 SHALL have port: op  input  3  operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-008 SHALL have port: out_valid  output  1  result and flags valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: result  output  16  operation result.
REQ-011 SHALL have the following flag ports: cout (output, 1, carry out of bit 15); overflow (output, 1, signed overflow); zero (output, 1, result == 0).

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE; the FSM SHALL enter IDLE on reset.
REQ-013 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-014 An accept SHALL occur on a clock edge where in_valid=1 and in_ready=1.
- At accept, a, b and op SHALL be latched.
- At accept, the nibble index SHALL be set to 0 and the FSM SHALL move to RUN.
- Input changes after the accept SHALL be ignored until the next accept.
REQ-015 In RUN, the block SHALL process one 4-bit nibble per cycle, nibble 0 (bits 3:0) first and nibble 3 last.
- Carry SHALL chain between nibbles through a 1-bit carry register.
REQ-016 Carry-in to nibble 0 SHALL be 0 for ADD and 1 for SUB/SLT.
- For SUB/SLT, each B nibble SHALL be inverted before the add.
REQ-017 AND/OR SHALL be computed bitwise per nibble with the carry register held at 0.
REQ-018 After nibble 3 is processed, the FSM SHALL move to DONE; out_valid SHALL be 1 exactly 4 cycles after the accept edge.
REQ-019 In DONE, result and the flags SHALL be held stable until a cycle with out_ready=1.
- On that edge, the FSM SHALL return to IDLE and out_valid SHALL fall.
- The block SHALL NOT accept a new bundle in the same cycle as the out_ready handshake.
REQ-020 cout SHALL be the carry out of bit 15 for ADD/SUB/SLT, and 0 for AND/OR.
REQ-021 overflow SHALL be (a[15]==b'[15]) && (sum[15]!=a[15]) for ADD/SUB/SLT, where b' is B or ~B as used; overflow SHALL be 0 for AND/OR.
REQ-022 For SLT, result SHALL be {15'b0, diff[15] XOR overflow}.
- SLT SHALL report signed a<b correctly, including when the subtraction overflows.
REQ-023 zero SHALL be 1 when all 16 result bits are 0, evaluated on the final result.
REQ-024 Undefined op codes (011, 100, 101) SHALL complete with the normal 4-cycle latency and produce result=0x0000, zero=1, cout=0, overflow=0.
REQ-025 Outside DONE, out_valid SHALL be 0; result and the flags are don't-care outside DONE but SHALL NOT glitch while in DONE.

Reset
REQ-026 When reset is asserted, the following SHALL take effect immediately, regardless of clk:
- FSM state=IDLE;
- in_ready=1, out_valid=0;
- result=0x0000, cout=0, overflow=0, zero=0;
- carry register and nibble index cleared.
REQ-027 Reset asserted during RUN or DONE SHALL discard the operation in flight; no out_valid SHALL follow for that operation.
REQ-028 After reset deasserts, the block SHALL accept a bundle on the first clock edge that has in_valid=1.

Verification
REQ-029 ADD, a=0x7FFF, b=0x0001, accept at edge T -> out_valid=1 after edge T+4; result=0x8000, overflow=1, cout=0, zero=0.
REQ-030 SUB, a=0x1234, b=0x1234 -> result=0x0000, zero=1, cout=1, overflow=0.
REQ-031 SLT, a=0x8000, b=0x0001 -> result=0x0001, overflow=1 (the overflow-corrected path).
- SLT, a=0x0005, b=0xFFFF -> result=0x0000.
REQ-032 AND, a=0xF0F0, b=0xFF00 -> result=0xF000, cout=0; with out_ready held 0 for 10 cycles:
- out_valid and result stay stable throughout;
- in_ready stays 0 throughout;
- out_ready=1 -> IDLE on the next edge.
REQ-033 ADD accepted, reset pulsed at the 2nd RUN cycle -> out_valid never rises for that bundle and in_ready=1 immediately.
- A following ADD of 0x0001+0x0001 -> 0x0002 after 4 cycles.
REQ-034 Operands a and b randomized after the accept edge -> result reflects only the latched operands; op 100 -> result=0x0000, zero=1 after 4 cycles.
